// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: 4-word I/O window, byte FIFO, 8N1 serialiser (8E1 with parity option).
// Latency: register reads return exactly 1 cycle after the address; a queued byte starts its frame 1 cycle after reaching the FIFO head.
// Backpressure: none to the CPU; a TXDATA write while the FIFO is full is dropped and counted in DROPS.
//
// Ports:
//   clock               system clock, rising edge
//   reset               asynchronous active-low reset
//   memory_address      CPU word address (snooped)
//   memory_write_enable CPU write strobe (snooped)
//   memory_write_data   CPU write data (snooped); only [7:0] is used, as TXDATA
//   io_read_data        registered read data for the previous cycle's address
//   io_selected         registered window hit for the previous cycle's address
//   uart_tx             serial line, idles high
//
// Build option: define UART_TX_PARITY_EN to add an even-parity bit between the
// data bits and the stop bit; STATUS bit 3 then reads 1.
module uart_tx_mmio #(
    parameter logic [15:0] BASE_ADDRESS    = 16'hFFF0,
    parameter int unsigned CLOCKS_PER_BIT  = 434,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] memory_address,
    input  logic        memory_write_enable,
    input  logic [15:0] memory_write_data,
    output logic [15:0] io_read_data,
    output logic        io_selected,
    output logic        uart_tx
);
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int          CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int          BW    = $clog2(CLOCKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    localparam logic PARITY_EN = 1'b0;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // Address decode
    logic       hit;
    logic [1:0] offset;
    logic       wr_txdata, wr_drops;
    assign hit       = (memory_address[15:2] == BASE_ADDRESS[15:2]);
    assign offset    = memory_address[1:0];
    assign wr_txdata = hit && memory_write_enable && (offset == 2'd0);
    assign wr_drops  = hit && memory_write_enable && (offset == 2'd2);

    // Only the low byte of a TXDATA write carries payload.
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^memory_write_data[15:8];

    // FIFO state
    logic [7:0]                 mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              count_q;
    logic                       fifo_full, fifo_empty, push, pop, drop;

    // TX FSM state
    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          baud_last, busy;

    logic [15:0] drops_q;
    logic [15:0] rd_val;
    logic [15:0] io_read_data_q;
    logic        io_selected_q;

    // Full is judged on the pre-edge count, so a write on a pop cycle from a
    // full FIFO is still dropped.
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = wr_txdata && !fifo_full;
    assign drop       = wr_txdata && fifo_full;
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign baud_last  = (baud_q == BAUD_LAST);
    assign busy       = (state_q != S_IDLE);

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= memory_write_data[7:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drops_q <= '0;
        end else if (wr_drops) begin
            drops_q <= '0;
        end else if (drop && (drops_q != 16'hFFFF)) begin
            drops_q <= drops_q + 16'd1;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic parity_q;
`endif

    // Serialiser. uart_tx is registered, so each transition loads the value
    // for the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q <= mem_q[rd_ptr_q];
                        baud_q  <= '0;
                        state_q <= S_START;
                        tx_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^mem_q[rd_ptr_q];
`endif
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            // Next bit is shift_q[1] before this edge's shift lands.
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // Read mux uses pre-edge register values.
    always_comb begin
        rd_val = 16'h0000;
        case (offset)
            2'd1:    rd_val = {8'h00, 4'(count_q), PARITY_EN, busy, fifo_empty, fifo_full};
            2'd2:    rd_val = drops_q;
            default: rd_val = 16'h0000;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_selected_q  <= 1'b0;
            io_read_data_q <= '0;
        end else begin
            io_selected_q  <= hit;
            io_read_data_q <= hit ? rd_val : 16'h0000;
        end
    end

    assign io_read_data = io_read_data_q;
    assign io_selected  = io_selected_q;
    assign uart_tx      = tx_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLOCKS_PER_BIT=4 and an 8-entry FIFO.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// A background monitor decodes frames on uart_tx while mon_en is set.
module tb_uart_tx_mmio;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] memory_address = 16'h0000;
    logic        memory_write_enable = 1'b0;
    logic [15:0] memory_write_data = 16'h0000;
    logic [15:0] io_read_data;
    logic        io_selected;
    logic        uart_tx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rdat;
    logic        rsel;
    logic [9:0]  frame;
    logic        saw_low;

    logic       mon_en = 1'b0;
    logic [7:0] mon_b;
    logic       mon_stop;
    logic [8:0] rx_q[$];

    uart_tx_mmio #(
        .BASE_ADDRESS   (16'hFFF0),
        .CLOCKS_PER_BIT (4),
        .FIFO_DEPTH_LOG2(3)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .memory_address     (memory_address),
        .memory_write_enable(memory_write_enable),
        .memory_write_data  (memory_write_data),
        .io_read_data       (io_read_data),
        .io_selected        (io_selected),
        .uart_tx            (uart_tx)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        memory_address      = a;
        memory_write_data   = d;
        memory_write_enable = 1'b1;
        tick();
        memory_write_enable = 1'b0;
        memory_address      = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d, output logic s);
        memory_address      = a;
        memory_write_enable = 1'b0;
        tick();
        d = io_read_data;
        s = io_selected;
        memory_address = 16'h0000;
    endtask

    // Frame decoder: start seen at sample k=1, bit n (start=0) spans k=4n+1..4n+4,
    // so each bit is taken at k=4n+2.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (mon_en && uart_tx === 1'b0) begin
                repeat (5) @(posedge clock);
                #1 mon_b[0] = uart_tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (4) @(posedge clock);
                    #1 mon_b[i] = uart_tx;
                end
                repeat (4) @(posedge clock);
                #1 mon_stop = uart_tx;
                rx_q.push_back({mon_stop, mon_b});
            end
        end
    end

    initial begin
        // 1: reset
        reset = 1'b0;
        repeat (3) tick();
        check("rst_uart_tx", 16'(uart_tx), 16'h0001);
        check("rst_io_selected", 16'(io_selected), 16'h0000);
        check("rst_io_read_data", io_read_data, 16'h0000);
        reset = 1'b1;
        rd(16'hFFF1, rdat, rsel);
        check("status_after_reset", rdat, 16'h0002);
        check("status_sel", 16'(rsel), 16'h0001);

        // 2: single frame of 8'h55
        wr(16'hFFF0, 16'h1255);
        check("idle_before_start", 16'(uart_tx), 16'h0001);
        frame = {1'b1, 8'h55, 1'b0};
        memory_address = 16'hFFF1;
        for (int k = 1; k <= 41; k++) begin
            tick();
            if (k <= 40) check($sformatf("frame55_k%0d", k), 16'(uart_tx), 16'(frame[(k - 1) / 4]));
            if (k >= 2)  check($sformatf("busy_k%0d", k), 16'(io_read_data[2]), 16'h0001);
        end
        tick();
        check("status_after_frame", io_read_data, 16'h0002);
        memory_address = 16'h0000;

        // 3: burst of 10 writes, 10th dropped
        mon_en = 1'b1;
        for (int i = 1; i <= 10; i++) wr(16'hFFF0, 16'(i));
        rd(16'hFFF1, rdat, rsel);
        check("status_full", rdat, 16'h0085);
        rd(16'hFFF2, rdat, rsel);
        check("drops_one", rdat, 16'h0001);
        for (int t = 0; t < 600 && rx_q.size() < 9; t++) tick();
        check("rx_count", 16'(rx_q.size()), 16'd9);
        for (int i = 0; i < 9 && i < rx_q.size(); i++)
            check($sformatf("rx_byte%0d", i), 16'(rx_q[i]), 16'({1'b1, 8'(i + 1)}));
        repeat (100) tick();
        check("rx_no_extra", 16'(rx_q.size()), 16'd9);
        mon_en = 1'b0;

        // 4: DROPS clear and saturation
        wr(16'hFFF2, 16'hBEEF);
        rd(16'hFFF2, rdat, rsel);
        check("drops_cleared", rdat, 16'h0000);
        for (int i = 0; i < 68000; i++) wr(16'hFFF0, 16'(i));
        rd(16'hFFF2, rdat, rsel);
        check("drops_saturated", rdat, 16'hFFFF);
        repeat (500) tick();

        // 5: asynchronous reset mid-frame (DATA bit 3 of 8'hA5 is 0)
        rd(16'hFFF1, rdat, rsel);
        check("status_drained", rdat, 16'h0002);
        wr(16'hFFF0, 16'h00A5);
        wr(16'hFFF0, 16'h003C);
        check("a5_start_bit", 16'(uart_tx), 16'h0000);
        repeat (17) tick();
        check("a5_data_bit3", 16'(uart_tx), 16'h0000);
        reset = 1'b0;
        #1;
        check("async_reset_line_high", 16'(uart_tx), 16'h0001);
        check("async_reset_sel", 16'(io_selected), 16'h0000);
        repeat (2) tick();
        reset = 1'b1;
        rd(16'hFFF1, rdat, rsel);
        check("status_after_midframe_reset", rdat, 16'h0002);
        rd(16'hFFF2, rdat, rsel);
        check("drops_after_reset", rdat, 16'h0000);
        saw_low = 1'b0;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (uart_tx !== 1'b1) saw_low = 1'b1;
        end
        check("no_frame_after_reset", 16'(saw_low), 16'h0000);

        // 6: unused offset and out-of-window accesses
        rd(16'hFFF3, rdat, rsel);
        check("off3_data", rdat, 16'h0000);
        check("off3_sel", 16'(rsel), 16'h0001);
        rd(16'hFFEF, rdat, rsel);
        check("miss_data", rdat, 16'h0000);
        check("miss_sel", 16'(rsel), 16'h0000);
        wr(16'hFFF3, 16'h00AA);
        wr(16'hFFEC, 16'h00BB);
        wr(16'hFFF1, 16'h00FF);
        rd(16'hFFF1, rdat, rsel);
        check("status_unchanged", rdat, 16'h0002);
        rd(16'hFFF2, rdat, rsel);
        check("drops_unchanged", rdat, 16'h0000);
        repeat (3) tick();
        check("line_idle_end", 16'(uart_tx), 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the CPU's data memory bus.
- Sits downstream of the cpu block, in parallel with data RAM.
- Snoops memory_address, memory_write_enable and memory_write_data. Decodes a 4-word I/O window and buffers outgoing bytes in a small FIFO.
- Serialises buffered bytes 8N1 on uart_tx.
- Read data returns through a top-level mux, selected by io_selected.

Parameters:
BASE_ADDRESS, 16'hFFF0, word address of the window; bits [1:0] must be 0
CLOCKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535
FIFO_DEPTH_LOG2, 3, log2 of FIFO entries (default 8 entries)

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
memory_address  input  16  CPU memory address
memory_write_enable  input  1  CPU write strobe
memory_write_data  input  16  CPU write data
io_read_data  output  16  registered read data for the addressed register
io_selected  output  1  registered; high when io_read_data is valid for the previous cycle's address
uart_tx  output  1  serial line; idles high

Behaviour:
- Hit: memory_address[15:2] == BASE_ADDRESS[15:2]. Register offset is memory_address[1:0].
- Register map:
  - Offset 0, TXDATA: write enqueues memory_write_data[7:0] (upper bits ignored); read returns 0.
  - Offset 1, STATUS: read {8'b0, fifo_count[3:0] zero-extended into bits[7:4], 1'b0, busy, empty, full} = bits 7..0. Writes are ignored.
  - Offset 2, DROPS: read returns a saturating count of TXDATA writes rejected while full. Any write clears it to 0.
  - Offset 3: reads 0; writes ignored.
- Read latency: exactly 1 cycle, matching block RAM.
  - Each cycle, io_selected <= hit.
  - io_read_data <= hit ? register[offset] : 0.
  - Register values are sampled before same-cycle updates.
- FIFO: circular buffer of 2^FIFO_DEPTH_LOG2 bytes, with read/write pointers and a count.
  - Pointers wrap modulo depth.
  - full = (count == depth); empty = (count == 0).
- Write while full: byte dropped, pointers unchanged, DROPS increments. DROPS saturates at 16'hFFFF.
- Full is evaluated before a same-cycle pop: a write on the cycle the FSM pops from a full FIFO is still dropped.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- TX FSM states: IDLE, START, DATA, STOP.
  - A baud counter runs 0..CLOCKS_PER_BIT-1.
  - Each of START, each DATA bit and STOP holds uart_tx for exactly CLOCKS_PER_BIT cycles.
  - IDLE: uart_tx=1. If FIFO not empty, pop the head into the shift register, clear the baud counter and go to START on the next edge.
  - START: uart_tx=0, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0], LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: uart_tx=1, then go to IDLE.
  - Because IDLE pops in a single cycle, a back-to-back frame occupies 10*CLOCKS_PER_BIT+1 cycles.
- busy = (state != IDLE).
- Reset (asynchronous, while reset=0):
  - state=IDLE, uart_tx=1, FIFO empty, pointers and count 0, DROPS=0, io_read_data=0, io_selected=0.
  - A frame in progress is abandoned; the line returns high immediately.

Optional Feature:
UART_TX_PARITY_EN:
- Defined: a PARITY state is inserted between DATA and STOP, transmitting even parity (XOR of the 8 data bits) for CLOCKS_PER_BIT cycles. STATUS bit 3 reads 1, signalling parity is present.
- Undefined: no PARITY state; frame is 8N1; STATUS bit 3 reads 0.

Test Plan:
1. Reset held low 3 cycles, then released (CLOCKS_PER_BIT=4) -> uart_tx=1, io_selected=0; read of 16'hFFF1 returns 16'h0002 one cycle later (empty).
2. Write 16'h1255 to 16'hFFF0 -> uart_tx bit sequence 0,1,0,1,0,1,0,1,0,1 (start, 8'h55 LSB first, stop), each bit 4 cycles; STATUS busy=1 during the frame and 0 after.
3. Write 10 bytes 8'h01..8'h0A back-to-back while the first frame is in progress -> first byte pops immediately, 8 queued, 10th dropped; STATUS full=1, count=8; DROPS reads 1; all 9 accepted bytes transmitted in order.
4. Write to 16'hFFF2 -> DROPS reads 0 next cycle. Then 65536+ rejected writes -> DROPS holds at 16'hFFFF.
5. Assert reset mid-frame during DATA bit 3 -> uart_tx=1 within the same cycle (asynchronous); FIFO empty after release; no further frame.
6. Reads of 16'hFFF3 and 16'hFFEF -> 16'hFFF3 gives io_selected=1, data 0; 16'hFFEF gives io_selected=0, data 0; FIFO and DROPS unchanged.
